// File: rtl/nybble_pkg.sv
// Shared definitions for the nybbleForth fetch stage: opcode values, operand lengths
// and the tagged byte layout kept in the prefetch FIFO.
package nybble_pkg;

    localparam int DEPTH_DEFAULT = 4;

    typedef enum logic [3:0] {
        OP_NOOP    = 4'd0,
        OP_LOAD    = 4'd1,
        OP_CALL    = 4'd2,
        OP_EXIT    = 4'd3,
        OP_LIT     = 4'd4,
        OP_RFROM   = 4'd7,
        OP_ADD     = 4'd8,
        OP_NAND    = 4'd9,
        OP_TOR     = 4'd10,
        OP_ZBRANCH = 4'd11,
        OP_STORE   = 4'd12
    } opcode_e;

    localparam logic OPND_BYTE = 1'b0;
    localparam logic OPND_WORD = 1'b1;

    // FIFO entry: byte address in [23:8], byte value in [7:0]
    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } fetch_entry_t;

    function automatic logic [15:0] sext8(input logic [7:0] b);
        return {{8{b[7]}}, b};
    endfunction

endpackage

// File: rtl/nybble_byte_fifo.sv
// Small prefetch FIFO of address-tagged bytes. Exposes the head and the entry after it
// so a 16-bit operand can be consumed in one cycle; flush empties it instantly.
module nybble_byte_fifo
    import nybble_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     push,
    input  logic [23:0]              push_entry,
    input  logic                     pop1,
    input  logic                     pop2,
    output logic [$clog2(DEPTH):0]   count,
    output logic [23:0]              head,
    output logic [7:0]               head1_data
);

    localparam int AW = $clog2(DEPTH);

    logic [23:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [AW:0]   w_pop_n;
    logic [23:0]   w_head1;

    assign w_pop_n = pop2 ? (AW+1)'(2) : (pop1 ? (AW+1)'(1) : (AW+1)'(0));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            // pointers are AW bits wide, so a pop of 2 wraps correctly even at DEPTH=2
            r_rd_ptr <= r_rd_ptr + w_pop_n[AW-1:0];
            r_count  <= r_count + (AW+1)'(push) - w_pop_n;
        end
    end

    always_ff @(posedge clock) begin
        if (push)
            r_mem[r_wr_ptr] <= push_entry;
    end

    assign count      = r_count;
    assign head       = r_mem[r_rd_ptr];
    assign w_head1    = r_mem[r_rd_ptr + AW'(1)];
    assign head1_data = w_head1[7:0];

    a_no_push_when_full: assert property (@(posedge clock) disable iff (reset)
        (push && !pop1 && !pop2) |-> (r_count < (AW+1)'(DEPTH)));

endmodule

// File: rtl/nybble_fetch.sv
// Instruction prefetch for the nybbleForth core: fills a byte FIFO from memory, hands
// out opcodes high nibble first, serves inline operands, and flushes on redirect.
module nybble_fetch
    import nybble_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_data,
    output logic        op_valid,
    output logic [3:0]  op,
    output logic [15:0] op_pc,
    input  logic        op_ready,
    input  logic        opnd_req,
    input  logic        opnd_len,
    output logic        opnd_valid,
    output logic [15:0] opnd,
    input  logic        redirect,
    input  logic [15:0] redirect_pc
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic          r_started;
    logic [15:0]   r_fetch_pc;
    logic          r_hold_valid;
    logic [3:0]    r_hold_nib;
    logic [15:0]   r_hold_pc;

    logic [CW-1:0] w_count;
    logic [23:0]   w_head;
    logic [7:0]    w_head1_data;
    logic          w_has1;
    logic          w_has2;
    logic          w_push;
    logic          w_pop1;
    logic          w_pop2;
    logic          w_op_xfer;
    logic          w_opnd_xfer;

    nybble_byte_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clock      (clock),
        .reset      (reset),
        .flush      (redirect),
        .push       (w_push),
        .push_entry ({mem_addr, mem_data}),
        .pop1       (w_pop1),
        .pop2       (w_pop2),
        .count      (w_count),
        .head       (w_head),
        .head1_data (w_head1_data)
    );

    assign w_has1   = (w_count != '0);
    assign w_has2   = (w_count >= CW'(2));

    // r_started keeps mem_req low while reset is held and for the first edge after it
    assign mem_req  = r_started && (w_count < CW'(DEPTH)) && !redirect;
    assign mem_addr = r_fetch_pc;
    assign w_push   = mem_req && mem_ack;

    always_comb begin
        op_valid   = 1'b0;
        op         = 4'h0;
        op_pc      = 16'h0000;
        opnd_valid = 1'b0;
        opnd       = 16'h0000;
        if (!opnd_req && (r_hold_valid || w_has1)) begin
            op_valid = 1'b1;
            if (r_hold_valid) begin
                op    = r_hold_nib;
                op_pc = r_hold_pc;
            end else begin
                op    = w_head[7:4];
                op_pc = w_head[23:8];
            end
        end
        if (opnd_req && ((opnd_len == OPND_WORD) ? w_has2 : w_has1)) begin
            opnd_valid = 1'b1;
            opnd       = (opnd_len == OPND_WORD) ? {w_head1_data, w_head[7:0]}
                                                 : sext8(w_head[7:0]);
        end
    end

    assign w_op_xfer   = op_valid && op_ready && !redirect;
    assign w_opnd_xfer = opnd_valid && !redirect;
    assign w_pop1      = (w_op_xfer && !r_hold_valid) || (w_opnd_xfer && opnd_len == OPND_BYTE);
    assign w_pop2      = w_opnd_xfer && (opnd_len == OPND_WORD);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_started  <= 1'b0;
            r_fetch_pc <= 16'h0000;
        end else begin
            r_started <= 1'b1;
            if (redirect)
                r_fetch_pc <= redirect_pc;
            else if (w_push)
                r_fetch_pc <= r_fetch_pc + 16'd1;
        end
    end

    // The hold register keeps the low nibble of the byte whose high nibble was just taken
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_hold_valid <= 1'b0;
            r_hold_nib   <= 4'h0;
            r_hold_pc    <= 16'h0000;
        end else if (redirect) begin
            r_hold_valid <= 1'b0;
        end else if (w_op_xfer) begin
            if (r_hold_valid) begin
                r_hold_valid <= 1'b0;
            end else begin
                r_hold_valid <= 1'b1;
                r_hold_nib   <= w_head[3:0];
                r_hold_pc    <= w_head[23:8];
            end
        end
    end

    a_opnd_needs_hold: assert property (@(posedge clock) disable iff (reset)
        opnd_req |-> r_hold_valid);

endmodule

// File: tb/tb_nybble_fetch.sv
// Directed self-checking bench for nybble_fetch with a zero-wait memory model.
module tb_nybble_fetch;
    import nybble_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_data;
    logic        op_valid;
    logic [3:0]  op;
    logic [15:0] op_pc;
    logic        op_ready = 1'b0;
    logic        opnd_req = 1'b0;
    logic        opnd_len = 1'b0;
    logic        opnd_valid;
    logic [15:0] opnd;
    logic        redirect = 1'b0;
    logic [15:0] redirect_pc = 16'h0000;

    logic        ackEn = 1'b0;
    logic        ackForce = 1'b0;
    logic [7:0]  mem [0:65535];
    int          ackCount;
    logic [15:0] ackAddr [0:255];
    int          errors = 0;
    int          checks = 0;

    nybble_fetch #(.DEPTH(4)) dut (
        .clock(clock), .reset(reset),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_data(mem_data),
        .op_valid(op_valid), .op(op), .op_pc(op_pc), .op_ready(op_ready),
        .opnd_req(opnd_req), .opnd_len(opnd_len), .opnd_valid(opnd_valid), .opnd(opnd),
        .redirect(redirect), .redirect_pc(redirect_pc)
    );

    always #5 clock = ~clock;

    assign mem_ack  = (mem_req && ackEn) || ackForce;
    assign mem_data = mem[mem_addr];

    always @(posedge clock) begin
        if (!reset && mem_req && mem_ack) begin
            ackAddr[ackCount[7:0]] <= mem_addr;
            ackCount <= ackCount + 1;
        end
    end

    task automatic stepCycle();
        @(posedge clock);
        #1;
    endtask

    task automatic clearMem();
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    endtask

    task automatic applyReset();
        reset = 1'b1;
        op_ready = 1'b0; opnd_req = 1'b0; opnd_len = 1'b0;
        redirect = 1'b0; redirect_pc = 16'h0000;
        ackEn = 1'b0; ackForce = 1'b0;
        stepCycle();
        stepCycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        applyReset();
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_addr, op_valid, op, op_pc, opnd_valid, opnd} !== 55'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h required 0",
                     {mem_req, mem_addr, op_valid, op, op_pc, opnd_valid, opnd});
        end
        reset = 1'b0;
    endtask

    task automatic test_literal_word();
        applyReset();
        clearMem();
        mem[0] = 8'h41; mem[1] = 8'h34; mem[2] = 8'h12; mem[3] = 8'h80;
        ackEn = 1'b1;
        repeat (8) stepCycle();
        checks++;
        if ({op_valid, op, op_pc} !== {1'b1, 4'h4, 16'h0000}) begin
            errors++; $display("[TB] FAIL lit_op: got %h required %h", {op_valid, op, op_pc}, {1'b1, 4'h4, 16'h0000});
        end
        op_ready = 1'b1; stepCycle(); op_ready = 1'b0;
        opnd_req = 1'b1; opnd_len = OPND_WORD;
        #1;
        checks++;
        if ({op_valid, opnd_valid, opnd} !== {1'b0, 1'b1, 16'h1234}) begin
            errors++; $display("[TB] FAIL lit_word: got %h required %h", {op_valid, opnd_valid, opnd}, {1'b0, 1'b1, 16'h1234});
        end
        stepCycle();
        opnd_req = 1'b0;
        #1;
        checks++;
        if ({op_valid, op, op_pc} !== {1'b1, 4'h1, 16'h0000}) begin
            errors++; $display("[TB] FAIL lit_low_nibble: got %h required %h", {op_valid, op, op_pc}, {1'b1, 4'h1, 16'h0000});
        end
        op_ready = 1'b1; stepCycle();
        checks++;
        if ({op_valid, op, op_pc} !== {1'b1, 4'h8, 16'h0003}) begin
            errors++; $display("[TB] FAIL after_lit_hi: got %h required %h", {op_valid, op, op_pc}, {1'b1, 4'h8, 16'h0003});
        end
        stepCycle();
        checks++;
        if ({op_valid, op, op_pc} !== {1'b1, 4'h0, 16'h0003}) begin
            errors++; $display("[TB] FAIL after_lit_lo: got %h required %h", {op_valid, op, op_pc}, {1'b1, 4'h0, 16'h0003});
        end
        op_ready = 1'b0;
    endtask

    task automatic test_zbranch_redirect();
        applyReset();
        clearMem();
        mem[16'h000F] = 8'h9A; mem[16'h0010] = 8'hB0; mem[16'h0011] = 8'hFE;
        ackEn = 1'b1;
        redirect = 1'b1; redirect_pc = 16'h0010;
        stepCycle();
        redirect = 1'b0;
        for (int i = 0; i < 20 && !op_valid; i++) stepCycle();
        checks++;
        if ({op_valid, op, op_pc} !== {1'b1, 4'hB, 16'h0010}) begin
            errors++; $display("[TB] FAIL zbr_op: got %h required %h", {op_valid, op, op_pc}, {1'b1, 4'hB, 16'h0010});
        end
        op_ready = 1'b1; stepCycle(); op_ready = 1'b0;
        opnd_req = 1'b1; opnd_len = OPND_BYTE;
        #1;
        for (int i = 0; i < 20 && !opnd_valid; i++) stepCycle();
        checks++;
        if ({opnd_valid, opnd} !== {1'b1, 16'hFFFE}) begin
            errors++; $display("[TB] FAIL zbr_offset: got %h required %h", {opnd_valid, opnd}, {1'b1, 16'hFFFE});
        end
        stepCycle();
        opnd_req = 1'b0;
        #1;
        checks++;
        if ({op_valid, op, op_pc} !== {1'b1, 4'h0, 16'h0010}) begin
            errors++; $display("[TB] FAIL zbr_low_nibble: got %h required %h", {op_valid, op, op_pc}, {1'b1, 4'h0, 16'h0010});
        end
        redirect = 1'b1; redirect_pc = 16'h000F;
        stepCycle();
        redirect = 1'b0;
        #1;
        checks++;
        if ({op_valid, opnd_valid} !== 2'b00) begin
            errors++; $display("[TB] FAIL redirect_bubble: got %b required 00", {op_valid, opnd_valid});
        end
        for (int i = 0; i < 20 && !op_valid; i++) stepCycle();
        checks++;
        if ({op_valid, op, op_pc} !== {1'b1, 4'h9, 16'h000F}) begin
            errors++; $display("[TB] FAIL redirect_target: got %h required %h", {op_valid, op, op_pc}, {1'b1, 4'h9, 16'h000F});
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] seq [8];
        int base;
        int idx;
        logic [7:0] b;
        logic [3:0] expNib;
        seq = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0};
        applyReset();
        clearMem();
        for (int i = 0; i < 8; i++) mem[i] = seq[i];
        ackEn = 1'b1;
        base = ackCount;
        repeat (20) stepCycle();
        checks++;
        if (ackCount - base != 4) begin
            errors++; $display("[TB] FAIL stall_ack_count: got %0d required 4", ackCount - base);
        end
        checks++;
        if ({mem_req, mem_addr} !== {1'b0, 16'h0004}) begin
            errors++; $display("[TB] FAIL stall_req: got %h required %h", {mem_req, mem_addr}, {1'b0, 16'h0004});
        end
        op_ready = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 100 && idx < 16; cyc++) begin
            if (op_valid) begin
                b = seq[idx / 2];
                expNib = (idx % 2 == 0) ? b[7:4] : b[3:0];
                checks++;
                if ({op, op_pc} !== {expNib, 16'(idx / 2)}) begin
                    errors++; $display("[TB] FAIL stream_op%0d: got %h required %h", idx, {op, op_pc}, {expNib, 16'(idx / 2)});
                end
                idx++;
            end
            stepCycle();
        end
        op_ready = 1'b0;
        checks++;
        if (idx != 16) begin
            errors++; $display("[TB] FAIL stream_timeout: got %0d ops required 16", idx);
        end
    endtask

    task automatic test_redirect_with_ack();
        applyReset();
        clearMem();
        mem[16'h0000] = 8'h77; mem[16'h0100] = 8'h5C;
        stepCycle();
        checks++;
        if ({mem_req, mem_addr} !== {1'b1, 16'h0000}) begin
            errors++; $display("[TB] FAIL pending_req: got %h required %h", {mem_req, mem_addr}, {1'b1, 16'h0000});
        end
        redirect = 1'b1; redirect_pc = 16'h0100; ackForce = 1'b1;
        stepCycle();
        redirect = 1'b0; ackForce = 1'b0; ackEn = 1'b1;
        #1;
        checks++;
        if (op_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL discard_bubble: got %b required 0", op_valid);
        end
        for (int i = 0; i < 20 && !op_valid; i++) stepCycle();
        checks++;
        if ({op_valid, op, op_pc} !== {1'b1, 4'h5, 16'h0100}) begin
            errors++; $display("[TB] FAIL discard_first: got %h required %h", {op_valid, op, op_pc}, {1'b1, 4'h5, 16'h0100});
        end
        op_ready = 1'b1; stepCycle();
        checks++;
        if ({op_valid, op, op_pc} !== {1'b1, 4'hC, 16'h0100}) begin
            errors++; $display("[TB] FAIL discard_second: got %h required %h", {op_valid, op, op_pc}, {1'b1, 4'hC, 16'h0100});
        end
        stepCycle();
        checks++;
        if ({op_valid, op, op_pc} !== {1'b1, 4'h0, 16'h0101}) begin
            errors++; $display("[TB] FAIL discard_third: got %h required %h", {op_valid, op, op_pc}, {1'b1, 4'h0, 16'h0101});
        end
        op_ready = 1'b0;
    endtask

    task automatic test_pc_wrap();
        logic [19:0] expOps [6];
        int base;
        int idx;
        logic [7:0] bi;
        expOps = '{{4'hA, 16'hFFFF}, {4'h1, 16'hFFFF}, {4'h2, 16'h0000},
                   {4'h3, 16'h0000}, {4'h4, 16'h0001}, {4'h5, 16'h0001}};
        applyReset();
        clearMem();
        mem[16'hFFFF] = 8'hA1; mem[16'h0000] = 8'h23; mem[16'h0001] = 8'h45;
        ackEn = 1'b1;
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        stepCycle();
        redirect = 1'b0;
        base = ackCount;
        op_ready = 1'b1;
        idx = 0;
        for (int cyc = 0; cyc < 50 && idx < 6; cyc++) begin
            if (op_valid) begin
                checks++;
                if ({op, op_pc} !== expOps[idx]) begin
                    errors++; $display("[TB] FAIL wrap_op%0d: got %h required %h", idx, {op, op_pc}, expOps[idx]);
                end
                idx++;
            end
            stepCycle();
        end
        op_ready = 1'b0;
        bi = base[7:0];
        checks++;
        if ({ackAddr[bi], ackAddr[bi + 8'd1], ackAddr[bi + 8'd2]} !== {16'hFFFF, 16'h0000, 16'h0001}) begin
            errors++; $display("[TB] FAIL wrap_fetch_addr: got %h required %h",
                               {ackAddr[bi], ackAddr[bi + 8'd1], ackAddr[bi + 8'd2]}, {16'hFFFF, 16'h0000, 16'h0001});
        end
    endtask

    task automatic test_reset_midfetch();
        int base;
        applyReset();
        clearMem();
        mem[0] = 8'h11; mem[1] = 8'h22; mem[2] = 8'h33; mem[3] = 8'h44;
        ackEn = 1'b1;
        base = ackCount;
        for (int i = 0; i < 20 && (ackCount - base) < 2; i++) stepCycle();
        ackEn = 1'b0;
        #1;
        checks++;
        if ({mem_req, mem_addr, op_valid} !== {1'b1, 16'h0002, 1'b1}) begin
            errors++; $display("[TB] FAIL midfetch_state: got %h required %h", {mem_req, mem_addr, op_valid}, {1'b1, 16'h0002, 1'b1});
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({mem_req, mem_addr, op_valid, op, op_pc, opnd_valid, opnd} !== 55'd0) begin
            errors++; $display("[TB] FAIL midfetch_reset: got %h required 0",
                               {mem_req, mem_addr, op_valid, op, op_pc, opnd_valid, opnd});
        end
        ackEn = 1'b1;
        stepCycle();
        stepCycle();
        checks++;
        if (ackCount - base != 2) begin
            errors++; $display("[TB] FAIL late_ack: got %0d acks required 2", ackCount - base);
        end
        reset = 1'b0;
        base = ackCount;
        for (int i = 0; i < 20 && !op_valid; i++) stepCycle();
        checks++;
        if ({op_valid, op, op_pc, ackAddr[base[7:0]]} !== {1'b1, 4'h1, 16'h0000, 16'h0000}) begin
            errors++; $display("[TB] FAIL restart_addr0: got %h required %h",
                               {op_valid, op, op_pc, ackAddr[base[7:0]]}, {1'b1, 4'h1, 16'h0000, 16'h0000});
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_literal_word();
        test_zbranch_redirect();
        test_back_to_back();
        test_redirect_with_ack();
        test_pc_wrap();
        test_reset_midfetch();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
